// File: rtl/wave_meter_pkg.sv
// Shared types and constants for the DDS waveform meter.
// Holds the FSM state encoding and counter helpers.
package wave_meter_pkg;

    localparam int TMO_W_DEF = 24;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] a,
        input logic        b
    );
        if (a == CNT_MAX) begin
            return a;
        end
        return a + {31'd0, b};
    endfunction

endpackage

// File: rtl/wave_meter_msb_edge_det.sv
// Registers the DDS MSB and flags a 0->1 transition.
// The registered copy doubles as the sample used by the high counter.
module msb_edge_det (
    input  logic CLK,
    input  logic RESET,
    input  logic msb,
    output logic msb_d,
    output logic rise
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            msb_d <= 1'b0;
        end else begin
            msb_d <= msb;
        end
    end

    assign rise = msb & ~msb_d;

endmodule

// File: rtl/wave_meter.sv
// Measures period and high time of the DDS MSB over NPER periods,
// aborting with TIMEOUT when edges stop arriving.
module wave_meter
    import wave_meter_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] DDS_IN,
    input  logic [7:0]  NPER,
    output logic        BUSY,
    output logic        VALID,
    output logic [31:0] PERIOD,
    output logic [31:0] HIGH,
    output logic        TIMEOUT
);

    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
    // Compare one short of all-ones so the exit edge lands when the
    // counter would reach 2^TMO_W-1.
    localparam logic [TMO_W-1:0] TMO_LIM = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t state;
    state_t state_nxt;

    logic             msb_d;
    logic             rise;
    logic [7:0]       nper_q;
    logic [7:0]       edge_cnt;
    logic [31:0]      period_cnt;
    logic [31:0]      high_cnt;
    logic [31:0]      period_nxt;
    logic [31:0]      high_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             close;
    logic             unused_dds;

    assign unused_dds = ^DDS_IN[30:0];

    msb_edge_det u_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .msb   (DDS_IN[31]),
        .msb_d (msb_d),
        .rise  (rise)
    );

    // Counters run on the registered MSB, so the arming rise cycle is
    // included and the closing rise cycle is not.
    assign period_nxt = sat_inc(period_cnt, 1'b1);
    assign high_nxt   = sat_inc(high_cnt, msb_d);
    assign tmo_hit    = (tmo_cnt == TMO_LIM);
    assign close      = rise && ((edge_cnt + 8'd1) == nper_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_nxt = MEAS;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    if (close) begin
                        state_nxt = DONE;
                    end
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        BUSY  = 1'b0;
        VALID = 1'b0;
        unique case (state)
            IDLE: ;
            ARM:  BUSY  = 1'b1;
            MEAS: BUSY  = 1'b1;
            DONE: VALID = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            nper_q     <= 8'd0;
            edge_cnt   <= 8'd0;
            period_cnt <= 32'd0;
            high_cnt   <= 32'd0;
            tmo_cnt    <= '0;
            PERIOD     <= 32'd0;
            HIGH       <= 32'd0;
            TIMEOUT    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        nper_q  <= (NPER == 8'd0) ? 8'd1 : NPER;
                        tmo_cnt <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        period_cnt <= 32'd0;
                        high_cnt   <= 32'd0;
                        edge_cnt   <= 8'd0;
                        tmo_cnt    <= '0;
                    end else if (tmo_hit) begin
                        PERIOD  <= 32'd0;
                        HIGH    <= 32'd0;
                        TIMEOUT <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                MEAS: begin
                    period_cnt <= period_nxt;
                    high_cnt   <= high_nxt;
                    if (rise) begin
                        tmo_cnt  <= '0;
                        edge_cnt <= edge_cnt + 8'd1;
                        if (close) begin
                            PERIOD  <= period_nxt;
                            HIGH    <= high_nxt;
                            TIMEOUT <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        PERIOD  <= 32'd0;
                        HIGH    <= 32'd0;
                        TIMEOUT <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_meter.sv
// Scoreboard bench for wave_meter: directed waveforms, queued
// expectations, and a monitor per DUT instance.
module tb_wave_meter;

    typedef struct {
        logic [31:0] period;
        logic [31:0] high;
        logic        tmo;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET, START, RESET_T, START_T;
    logic [7:0]  NPER, NPER_T;
    logic [31:0] DDS_IN, DDS_T;
    logic        BUSY, VALID, TIMEOUT;
    logic [31:0] PERIOD, HIGH;
    logic        BUSY_T, VALID_T, TIMEOUT_T;
    logic [31:0] PERIOD_T, HIGH_T;

    exp_t q[$];
    exp_t qt[$];
    exp_t em, et;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   mode = 0;
    logic [31:0] acc = 32'd0;

    always #5 CLK = ~CLK;

    wave_meter dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DDS_IN(DDS_IN),
        .NPER(NPER), .BUSY(BUSY), .VALID(VALID), .PERIOD(PERIOD),
        .HIGH(HIGH), .TIMEOUT(TIMEOUT)
    );

    wave_meter #(.TMO_W(4)) dut_t (
        .CLK(CLK), .RESET(RESET_T), .START(START_T), .DDS_IN(DDS_T),
        .NPER(NPER_T), .BUSY(BUSY_T), .VALID(VALID_T), .PERIOD(PERIOD_T),
        .HIGH(HIGH_T), .TIMEOUT(TIMEOUT_T)
    );

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        acc <= acc + 32'h1000_0000;
    end

    always_comb begin
        DDS_IN = 32'd0;
        case (mode)
            1: DDS_IN = ((cyc % 8) < 4) ? 32'h8000_0000 : 32'd0;
            2: DDS_IN = acc;
            3: DDS_IN = ((cyc % 3) == 0) ? 32'h8000_0000 : 32'd0;
            default: DDS_IN = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (VALID === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got VALID=1, expected none");
            end else begin
                em = q.pop_front();
                chk("period", PERIOD, em.period);
                chk("high", HIGH, em.high);
                chk("timeout", 32'(TIMEOUT), 32'(em.tmo));
                chk("busy_in_done", 32'(BUSY), 32'd0);
            end
        end
    end

    always @(negedge CLK) begin
        if (VALID_T === 1'b1) begin
            if (qt.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid_t: got VALID=1, expected none");
            end else begin
                et = qt.pop_front();
                chk("t_period", PERIOD_T, et.period);
                chk("t_high", HIGH_T, et.high);
                chk("t_timeout", 32'(TIMEOUT_T), 32'(et.tmo));
                chk("t_latency", 32'(cyc - t_start), 32'd15);
            end
        end
    end

    task automatic wait_valid(input int maxc, input bit tdut);
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK);
            if ((tdut ? VALID_T : VALID) === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_valid: got no VALID in %0d cycles, expected one", maxc);
    endtask

    task automatic start_meas(input logic [7:0] n);
        @(posedge CLK);
        #1;
        NPER  = n;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_valid"}, 32'(VALID), 32'd0);
        chk({tag, "_period"}, PERIOD, 32'd0);
        chk({tag, "_high"}, HIGH, 32'd0);
        chk({tag, "_timeout"}, 32'(TIMEOUT), 32'd0);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; NPER = 8'd0;
        RESET_T = 1'b1; START_T = 1'b0; NPER_T = 8'd1; DDS_T = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        RESET_T = 1'b0;
        @(negedge CLK);
        check_zero("reset");

        // square wave, period 8 with 4 high
        mode = 1;
        q.push_back('{32'd8, 32'd4, 1'b0});
        start_meas(8'd1);
        @(negedge CLK);
        chk("busy_meas", 32'(BUSY), 32'd1);
        wait_valid(100, 1'b0);
        // START coincident with VALID must be ignored
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        chk("start_on_valid", 32'(BUSY), 32'd0);
        chk("hold_period", PERIOD, 32'd8);

        // DDS sawtooth, period 16, four periods
        mode = 2;
        q.push_back('{32'd64, 32'd32, 1'b0});
        start_meas(8'd4);
        wait_valid(200, 1'b0);

        // 1-of-3 pulse train, 255 periods
        mode = 3;
        q.push_back('{32'd765, 32'd255, 1'b0});
        start_meas(8'd255);
        wait_valid(1000, 1'b0);

        // DC input on the narrow-timeout instance
        qt.push_back('{32'd0, 32'd0, 1'b1});
        @(posedge CLK);
        #1;
        START_T = 1'b1;
        @(posedge CLK);
        #1;
        t_start = cyc;
        START_T = 1'b0;
        wait_valid(50, 1'b1);

        // NPER=0 with repeated START while busy
        mode = 1;
        q.push_back('{32'd8, 32'd4, 1'b0});
        start_meas(8'd0);
        repeat (3) begin
            @(posedge CLK);
            #1;
            START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        wait_valid(100, 1'b0);
        repeat (30) @(negedge CLK);

        // reset in the middle of a measurement
        mode = 2;
        start_meas(8'd4);
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        chk("busy_before_rst", 32'(BUSY), 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_zero("mid_reset");
        repeat (100) @(negedge CLK);

        // RESET overrides a same-cycle START
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("rst_vs_start", 32'(BUSY), 32'd0);

        chk("q_empty", 32'(q.size()), 32'd0);
        chk("qt_empty", 32'(qt.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 Parameter TMO_W, default 24, sets the timeout counter width; timeout limit is 2^TMO_W-1 clocks.
REQ-002 CLK  input  1  single system clock; all logic on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  one-cycle request to begin a measurement; ignored while BUSY=1.
REQ-005 DDS_IN  input  32  waveform word from the DDS generator; only bit 31 (MSB) is measured.
REQ-006 NPER  input  8  number of MSB periods to accumulate; sampled on accepted START; 0 treated as 1.
REQ-007 BUSY  output  1  high from the cycle after an accepted START until VALID.
REQ-008 VALID  output  1  one-cycle pulse marking new PERIOD/HIGH/TIMEOUT values.
REQ-009 PERIOD  output  32  clocks between the arming rise and the NPER-th following rise.
REQ-010 HIGH  output  32  clocks with MSB=1 within the same window.
REQ-011 TIMEOUT  output  1  set with VALID when a measurement aborted for lack of edges.

Function
REQ-012 A rise SHALL be MSB=1 in the current cycle and MSB=0 in the previous cycle (registered msb_d).
REQ-013 FSM states SHALL be IDLE, ARM, MEAS, DONE.
REQ-014 IDLE: accepted START -> ARM; latch NPER; clear the timeout counter.
REQ-015 ARM: first rise -> MEAS; period, high and edge counters load 0 in that cycle; timeout counter clears.
REQ-016 MEAS: each cycle, period counter +1 and high counter +MSB; every rise increments the edge counter and clears the timeout counter.
REQ-017 MEAS: the rise that brings the edge count to NPER SHALL be excluded from the counts and move the FSM to DONE, latching PERIOD and HIGH.
REQ-018 DONE SHALL last exactly one cycle with VALID=1, BUSY=0, then return to IDLE.
REQ-019 Latency: VALID SHALL assert the cycle after the closing rise.
REQ-020 Period and high counters SHALL saturate at 32'hFFFFFFFF, never wrap.
REQ-021 In ARM or MEAS, the timeout counter reaching 2^TMO_W-1 without a rise -> DONE with TIMEOUT=1, PERIOD=0, HIGH=0.
REQ-022 Rise and timeout in the same cycle: the rise wins, no timeout.
REQ-023 PERIOD, HIGH and TIMEOUT SHALL hold their values until the next VALID.
REQ-024 START coincident with VALID SHALL be ignored; a new measurement needs START in IDLE.
REQ-025 A constant MSB (DC input) SHALL end only by timeout.

Reset
REQ-026 RESET SHALL force IDLE and zero BUSY, VALID, PERIOD, HIGH, TIMEOUT, msb_d and all counters.
REQ-027 RESET mid-measurement SHALL abort with no VALID pulse; RESET overrides a same-cycle START.

Structure
REQ-028 Package wave_meter_pkg SHALL hold the FSM state enum and the default TMO_W constant.
REQ-029 Sub-module msb_edge_det SHALL register the MSB and output the rise strobe; the FSM and counters live in wave_meter.

Verification
REQ-030 MSB square wave of period 8 (4 high), NPER=1, START -> VALID once, PERIOD=8, HIGH=4, TIMEOUT=0.
REQ-031 Driven by the DDS sawtooth with ADDER=32'h10000000 (period 16), NPER=4 -> PERIOD=64, HIGH=32.
REQ-032 DDS_IN held at 0, TMO_W=4, START -> VALID with TIMEOUT=1, PERIOD=0, HIGH=0, 15 clocks after START.
REQ-033 RESET pulsed while in MEAS -> BUSY=0 the next cycle, no VALID, all outputs 0.
REQ-034 START repeated while BUSY, and NPER=0 -> a single measurement, identical to NPER=1.
REQ-035 Period-1 toggle with a 1-clock high every 3 clocks, NPER=255 -> PERIOD=765, HIGH=255.
